// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
// Used by mem_arbiter and rd_tag_pipe.
package mem_arb_pkg;

    // Default geometry of the shared data RAM.
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Master identifier: 0 = CPU load/store path, 1 = loader/debug DMA.
    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

    // One in-flight read: which master must receive the returning data.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    // Round-robin choice on a conflict: the master that did not win last time.
    function automatic owner_t rr_pick(input owner_t last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag pipeline: a DEPTH-deep shift register of rd_tag_t entries that
// follows each read through the RAM so its data can be steered back to the
// master that issued it. A synchronous clear empties every stage.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    clear,
    input  rd_tag_t push_tag,
    output rd_tag_t pop_tag,
    output logic    any_valid
);

    rd_tag_t stage_q [DEPTH];

    // Shift one stage per cycle; stage 0 takes the tag of this cycle's accept.
    always_ff @(posedge clk) begin
        // NOTE: every stage is cleared on reset because the valid bits are
        // control state; a stale valid would produce a phantom response.
        // Non-blocking assignments keep all stages shifting from old values.
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // The oldest stage lines up with the RAM data returning this cycle.
    assign pop_tag = stage_q[DEPTH-1];

    // Any stage holding a read means data is still owed to a master.
    always_comb begin
        // NOTE: assigning the default first keeps this block free of latches.
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port data RAM.
// Master 0 is the CPU load/store path, master 1 the loader/debug DMA.
// At most one beat is accepted per cycle and drives the RAM command in that
// same cycle; reads are tracked by rd_tag_pipe so the data returning RD_LAT
// cycles later is delivered to the issuing master. A master may lock the RAM
// across a multi-beat sequence.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration in OPEN;
// without it master 0 has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1           // RAM read latency, 1..4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    owner_t            last_grant_q;

    // The accepted beat, selected from the winning master.
    logic              acc_valid;
    owner_t            acc_owner;
    logic              acc_we;
    logic              acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    rd_tag_t           push_tag;
    rd_tag_t           pop_tag;
    logic              pipe_busy;

`ifndef MEM_ARB_RR_EN
    // Fixed priority never consults the previous winner.
    logic              unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    // Grant: lock owner only while locked, otherwise arbitrate between requesters.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            unique case (state_q)
                LOCK0: m0_gnt = m0_req;
                LOCK1: m1_gnt = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
                        if (rr_pick(last_grant_q) == OWNER_M0) begin
                            m0_gnt = 1'b1;
                        end else begin
                            m1_gnt = 1'b1;
                        end
`else
                        m0_gnt = 1'b1;
`endif
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
            endcase
        end
    end

    // Steer the winner's command fields onto the accepted-beat bus.
    always_comb begin
        acc_valid = m0_gnt | m1_gnt;
        acc_owner = m1_gnt ? OWNER_M1 : OWNER_M0;
        acc_we    = m0_we;
        acc_lock  = m0_lock;
        acc_addr  = m0_addr;
        acc_wdata = m0_wdata;
        if (m1_gnt) begin
            acc_we    = m1_we;
            acc_lock  = m1_lock;
            acc_addr  = m1_addr;
            acc_wdata = m1_wdata;
        end
    end

    // RAM command: strobes and address only in a cycle with an accepted beat.
    always_comb begin
        ram_rd    = acc_valid & ~acc_we;
        ram_wr    = acc_valid &  acc_we;
        ram_addr  = acc_valid ? acc_addr  : '0;
        ram_wdata = acc_valid ? acc_wdata : '0;
    end

    // Every accepted read enters the tag pipe; writes need no response.
    always_comb begin
        push_tag       = '0;
        push_tag.valid = acc_valid & ~acc_we;
        push_tag.owner = acc_owner;
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .clear     (reset),
        .push_tag  (push_tag),
        .pop_tag   (pop_tag),
        .any_valid (pipe_busy)
    );

    // Response: hand returning RAM data to the owner of the exiting tag.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (!reset && pop_tag.valid) begin
            if (pop_tag.owner == OWNER_M0) begin
                m0_rvalid = 1'b1;
                m0_rdata  = ram_rdata;
            end else begin
                m1_rvalid = 1'b1;
                m1_rdata  = ram_rdata;
            end
        end
    end

    // Lock FSM next state: enter on a locked beat, leave when the owner
    // finishes with an unlocked beat or goes idle with lock dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OPEN: begin
                if (acc_valid && acc_lock) begin
                    state_d = (acc_owner == OWNER_M1) ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                if ((m0_gnt && !m0_lock) || (!m0_req && !m0_lock)) begin
                    state_d = OPEN;
                end
            end
            LOCK1: begin
                if ((m1_gnt && !m1_lock) || (!m1_req && !m1_lock)) begin
                    state_d = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    // Lock FSM state register; reset releases any held lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember the winner of every accepted beat for round-robin fairness.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWNER_M1;
        end else if (acc_valid) begin
            last_grant_q <= acc_owner;
        end
    end

    assign busy = !reset && (pipe_busy || (state_q != OPEN));

endmodule
